// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared access-size codes and wait-FSM state type for the MEM/WB stage
package mem_wb_stage_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// mem_wb_stage_load_formatter: big-endian byte/half extract with sign/zero extension and misalign detect
module mem_wb_stage_load_formatter
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        load_uns,
  input  logic [31:0] data,
  output logic [31:0] result,
  output logic        mis
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = addr[1] ? (addr[0] ? data[7:0] : data[15:8]) : (addr[0] ? data[23:16] : data[31:24]);
    h = addr[1] ? data[15:0] : data[31:16];
    result = size == SIZE_BYTE ? {{24{~load_uns & b[7]}}, b}
           : size == SIZE_HALF ? {{16{~load_uns & h[15]}}, h}
           : data;
    mis = (size == SIZE_HALF & addr[0]) | (size == SIZE_WORD & |addr);
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-wait controller with access timeout and MEM/WB pipeline register
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic               MREQ_i,
  input  logic               WRITE_i,
  input  logic [1:0]         SIZE_i,
  input  logic [31:0]        DAD_i,
  input  logic [31:0]        data_in_i,
  input  logic               load_uns_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic               reg_we_i,
  input  logic               flush_i,
  input  logic               DACK_i,
  output logic               stall_o,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               bus_err_o,
  output logic               align_err_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t      state;
  logic [CW-1:0] cnt;
  logic        acc, tmo, mis, mis_acc, live;
  logic [31:0] fmt;
  logic        unused_dad;
  assign unused_dad = ^DAD_i[31:2];
  mem_wb_stage_load_formatter u_fmt (
    .size     (SIZE_i),
    .addr     (DAD_i[1:0]),
    .load_uns (load_uns_i),
    .data     (data_in_i),
    .result   (fmt),
    .mis      (mis)
  );
  always_comb begin
    acc = valid_i & MREQ_i;
    tmo = acc & ~DACK_i & (cnt == LAST);
    stall_o = acc & ~DACK_i & ~tmo;
    mis_acc = MREQ_i & mis;
    live = valid_i & ~flush_i & ~stall_o;
  end
  // The bus cycle is never abandoned: flush only suppresses the write-back, not the wait.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_RUN;
      cnt <= '0;
    end else if (state == ST_RUN) begin
      if (acc && !DACK_i) begin
        state <= ST_WAIT;
        cnt <= CW'(1);
      end
    end else if (DACK_i || cnt == LAST) begin
      state <= ST_RUN;
      cnt <= '0;
    end else
      cnt <= cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_valid_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_rd_o <= '0;
      wb_data_o <= '0;
      bus_err_o <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      wb_valid_o <= live;
      wb_we_o <= live & reg_we_i & ~mis_acc & ~tmo;
      bus_err_o <= live & tmo;
      align_err_o <= live & mis_acc;
      if (!stall_o) begin
        wb_rd_o <= rd_i;
        wb_data_o <= (MREQ_i & ~WRITE_i) ? fmt : data_in_i;
      end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized transactions checked against a transaction-level model
module tb_mem_wb_stage;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, valid = 0, mreq = 0, wr = 0, uns = 0, we = 0, flush = 0, dack = 0;
  logic [1:0] size = 0;
  logic [31:0] dad = 0, din = 0;
  logic [4:0] rd = 0;
  logic stall, wb_valid, wb_we, bus_err, align_err;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  int nvec = 0, nerr = 0;

  mem_wb_stage #(.TIMEOUT(TO), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .MREQ_i(mreq), .WRITE_i(wr), .SIZE_i(size),
    .DAD_i(dad), .data_in_i(din), .load_uns_i(uns), .rd_i(rd), .reg_we_i(we), .flush_i(flush),
    .DACK_i(dack), .stall_o(stall), .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .bus_err_o(bus_err), .align_err_o(align_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: bench did not finish");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic v, input logic m, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input logic u,
                     input logic [4:0] r, input logic e);
    valid = v; mreq = m; wr = w; size = sz; dad = a; din = d; uns = u; rd = r; we = e;
  endtask

  // Expected write-back data: big-endian lane pick by shifting, then extension.
  function automatic logic [31:0] exp_data();
    logic [31:0] v;
    if (!mreq || wr || size == 2'b00) return din;
    if (size == 2'b10) begin
      v = (din >> (24 - 8 * int'(dad[1:0]))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (din >> (16 - 16 * int'(dad[1]))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Called at a negedge. DACK rises in cycle `delay`; flush rises in cycle `flush_at`.
  task automatic run(input int delay, input int flush_at);
    bit acc, tmo, mis, fl, st;
    acc = valid && mreq;
    for (int k = 0; k < TO; k++) begin
      dack = (k == delay);
      flush = (k >= flush_at);
      #1;
      st = acc && k < delay && k < TO - 1;
      chk1("stall", stall, st);
      if (!st) break;
      @(negedge clk);
      chk1("bubble_valid", wb_valid, 1'b0);
      chk1("bubble_we", wb_we, 1'b0);
    end
    tmo = acc && delay >= TO;
    mis = mreq && (size == 2'b01 ? dad[0] : size == 2'b00 ? dad[1:0] != 2'b00 : 1'b0);
    fl = flush;
    @(negedge clk);
    chk1("wb_valid", wb_valid, valid && !fl);
    chk1("wb_we", wb_we, valid && !fl && we && !mis && !tmo);
    chk1("bus_err", bus_err, valid && !fl && tmo);
    chk1("align_err", align_err, valid && !fl && mis);
    if (valid) begin
      chk32("wb_rd", 32'(wb_rd), 32'(rd));
      chk32("wb_data", wb_data, exp_data());
    end
    valid = 0; flush = 0; dack = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    chk1("idle_valid", wb_valid, 1'b0);
    chk1("idle_bus_err", bus_err, 1'b0);
    chk1("idle_align_err", align_err, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_valid"}, wb_valid, 1'b0);
    chk1({tag, "_we"}, wb_we, 1'b0);
    chk32({tag, "_rd"}, 32'(wb_rd), 32'd0);
    chk32({tag, "_data"}, wb_data, 32'd0);
    chk1({tag, "_bus_err"}, bus_err, 1'b0);
    chk1({tag, "_align_err"}, align_err, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    set(1, 1, 0, 2'b00, 32'h100, 32'hDEADBEEF, 0, 5'd3, 1); run(0, 99);
    chk32("t1_const", wb_data, 32'hDEADBEEF);
    set(1, 1, 0, 2'b10, 32'h101, 32'h1280FF00, 0, 5'd4, 1); run(0, 99);
    chk32("lb_signed_const", wb_data, 32'hFFFFFF80);
    set(1, 1, 0, 2'b10, 32'h101, 32'h1280FF00, 1, 5'd5, 1); run(0, 99);
    chk32("lb_unsigned_const", wb_data, 32'h00000080);
    set(1, 1, 0, 2'b01, 32'h102, 32'h1280FF00, 0, 5'd6, 1); run(0, 99);
    set(1, 1, 0, 2'b01, 32'h100, 32'h8280FF00, 1, 5'd6, 1); run(0, 99);
    set(1, 1, 0, 2'b01, 32'h100, 32'hA5A55A5A, 0, 5'd8, 1); run(3, 99);
    set(1, 1, 0, 2'b00, 32'h104, 32'h01020304, 0, 5'd9, 1); run(10, 99);
    idle();
    set(1, 1, 0, 2'b00, 32'h102, 32'hCAFEF00D, 0, 5'd10, 1); run(0, 99);
    idle();
    set(1, 1, 0, 2'b00, 32'h102, 32'hCAFEF00D, 0, 5'd11, 1); run(3, 1);
    set(1, 1, 0, 2'b00, 32'h108, 32'hCAFEF00D, 0, 5'd12, 1); run(10, 2);
    set(1, 1, 1, 2'b10, 32'h10B, 32'h87654321, 0, 5'd13, 0); run(1, 99);
    set(1, 0, 0, 2'b00, 32'h3, 32'h0BADC0DE, 0, 5'd14, 1); run(0, 99);
    set(1, 0, 0, 2'b00, 32'h0, 32'h0BADC0DE, 0, 5'd15, 1); run(0, 0);
    set(1, 1, 0, 2'b00, 32'h200, 32'h11223344, 0, 5'd7, 1); run(0, 99);
    set(1, 1, 0, 2'b00, 32'h204, 32'h55, 0, 5'd9, 1);
    dack = 0;
    #1 chk1("pre_reset_stall", stall, 1'b1);
    @(negedge clk);
    @(negedge clk);
    valid = 0;
    rst_n = 0;
    #1 chk_zero("async_reset");
    chk1("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1;
    set(1, 1, 0, 2'b00, 32'h208, 32'h600DF00D, 0, 5'd17, 1); run(3, 99);
    for (int i = 0; i < 60; i++) begin
      set(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
          2'($urandom_range(0, 2)), $urandom, $urandom, 1'($urandom_range(0, 1)),
          5'($urandom), 1'($urandom_range(0, 1)));
      run(int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 99);
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
